// File: rtl/mod_lift_pkg.sv
// Shared types for the centered-lift unit: default residue width, modulus,
// residue word type and the lift FSM state encoding.
package mod_lift_pkg;

    localparam int W_BITS_L = 12;
    localparam int Q_MOD_L  = 3329;

    typedef logic [W_BITS_L-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REDUCE = 2'd1,
        LIFT   = 2'd2,
        HOLD   = 2'd3
    } lift_state_t;

endpackage

// File: rtl/mod_lift.sv
// Sequential centered lift: reduces a residue by repeated subtraction of Q,
// then maps it to the symmetric signed range around zero, double-width.
module mod_lift
    import mod_lift_pkg::*;
#(
    parameter int    W      = W_BITS_L,
    parameter int    WW     = 2*W_BITS_L,
    parameter word_t Q      = word_t'(Q_MOD_L),
    parameter int    MAXSUB = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_res,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [WW-1:0] out_val,
    output logic          out_sat,
    output logic          busy,
    output logic [1:0]    dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid and ready
    // are both high; out_valid/out_val/out_sat stay frozen until out_ready.

    localparam int            CW      = (MAXSUB < 1) ? 1 : $clog2(MAXSUB + 1);
    localparam logic [W:0]    Q_EXT   = (W+1)'(Q);
    localparam logic [W:0]    HALF    = Q_EXT >> 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(MAXSUB);

    lift_state_t   state;
    lift_state_t   state_nxt;
    logic [W:0]    r;
    logic [CW-1:0] cnt;
    logic          r_ge_q;
    logic          can_sub;

    // Returns {sat, value}; r - Q wraps to the two's complement negative on W+1 bits.
    function automatic logic [WW:0] centered_lift(input logic [W:0] rv);
        logic [W:0] diff;
        diff = rv - Q_EXT;
        if (rv >= Q_EXT)
            return {1'b1, {WW{1'b0}}};
        else if (rv > HALF)
            return {1'b0, {(WW-W-1){diff[W]}}, diff};
        else
            return {1'b0, {(WW-W-1){1'b0}}, rv};
    endfunction

    assign r_ge_q  = (r >= Q_EXT);
    assign can_sub = r_ge_q && (cnt < CNT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = REDUCE;
            REDUCE:  if (!can_sub) state_nxt = LIFT;
            LIFT:    state_nxt = HOLD;
            HOLD:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        busy      = (state != IDLE);
        dbg_state = state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r         <= '0;
            cnt       <= '0;
            out_val   <= '0;
            out_sat   <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        r   <= {1'b0, in_res};
                        cnt <= '0;
                    end
                end
                REDUCE: begin
                    if (can_sub) begin
                        r   <= r - Q_EXT;
                        cnt <= cnt + CW'(1);
                    end
                end
                LIFT: begin
                    {out_sat, out_val} <= centered_lift(r);
                    out_valid          <= 1'b1;
                end
                HOLD: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mod_lift.sv
// Bench for mod_lift: directed vectors on a Q=17 instance, a saturating
// MAXSUB=4 instance, and a round trip on a default-parameter instance.
module tb_mod_lift;
    import mod_lift_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    logic [16:0] exp_q[$];

    // Q=17, W=8 instance
    logic        a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b1;
    logic        a_out_sat, a_busy;
    logic [7:0]  a_in_res = '0;
    logic [15:0] a_out_val;
    logic [1:0]  a_dbg;

    // Q=17, W=8, MAXSUB=4 instance
    logic        s_in_valid = 1'b0, s_in_ready, s_out_valid, s_out_ready = 1'b1;
    logic        s_out_sat, s_busy;
    logic [7:0]  s_in_res = '0;
    logic [15:0] s_out_val;
    logic [1:0]  s_dbg;

    // default-parameter instance
    logic        d_in_valid = 1'b0, d_in_ready, d_out_valid, d_out_ready = 1'b1;
    logic        d_out_sat, d_busy;
    logic [W_BITS_L-1:0]   d_in_res = '0;
    logic [2*W_BITS_L-1:0] d_out_val;
    logic [1:0]  d_dbg;

    mod_lift #(.W(8), .WW(16), .Q(word_t'(17)), .MAXSUB(64)) u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_res(a_in_res), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_val(a_out_val), .out_sat(a_out_sat), .busy(a_busy), .dbg_state(a_dbg));

    mod_lift #(.W(8), .WW(16), .Q(word_t'(17)), .MAXSUB(4)) u_s (
        .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_res(s_in_res), .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_val(s_out_val), .out_sat(s_out_sat), .busy(s_busy), .dbg_state(s_dbg));

    mod_lift u_d (
        .clk(clk), .rst_n(rst_n), .in_valid(d_in_valid), .in_ready(d_in_ready),
        .in_res(d_in_res), .out_valid(d_out_valid), .out_ready(d_out_ready),
        .out_val(d_out_val), .out_sat(d_out_sat), .busy(d_busy), .dbg_state(d_dbg));

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: sat if more than maxsub subtractions would be needed,
    // otherwise the representative of res mod q nearest zero (ties positive).
    function automatic int lift_ref(input int res, input int q, input int maxsub, output bit sat);
        int v;
        sat = (res / q) > maxsub;
        if (sat) return 0;
        v = res % q;
        return (v > q / 2) ? v - q : v;
    endfunction

    // Checks every cycle instance A presents a result; pops on retirement.
    always @(negedge clk) begin
        if (rst_n && a_out_valid) begin
            if (exp_q.size() == 0) begin
                check("a_spurious_valid", a_out_valid, 0);
            end else begin
                check("a_out_val", $signed(a_out_val), $signed(exp_q[0][15:0]));
                check("a_out_sat", a_out_sat, exp_q[0][16]);
                if (a_out_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic send_a(input int res, input int exp_val, input int exp_lat, input int stall);
        bit sat;
        int mv;
        int lat;
        mv = lift_ref(res, 17, 64, sat);
        check("a_model_pin", mv, exp_val);
        @(negedge clk);
        check("a_in_ready_idle", a_in_ready, 1);
        a_out_ready = (stall == 0);
        a_in_valid  = 1'b1;
        a_in_res    = 8'(res);
        @(posedge clk);
        exp_q.push_back({sat, 16'(mv)});
        #1 a_in_valid = 1'b0;
        lat = 0;
        while (!a_out_valid && lat < 200) begin
            @(posedge clk);
            #1 lat++;
        end
        check("a_latency", lat, exp_lat);
        repeat (stall) begin
            @(negedge clk);
            check("a_hold_in_ready", a_in_ready, 0);
            check("a_hold_valid", a_out_valid, 1);
            a_in_valid = 1'b1;
            a_in_res   = 8'd3;
            @(posedge clk);
            #1 a_in_valid = 1'b0;
        end
        a_out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("a_retired_valid", a_out_valid, 0);
        check("a_retired_busy", a_busy, 0);
    endtask

    task automatic send_s(input int res, input int exp_val, input int exp_sat, input int exp_lat);
        bit sat;
        int mv;
        int lat;
        mv = lift_ref(res, 17, 4, sat);
        check("s_model_pin_val", mv, exp_val);
        check("s_model_pin_sat", sat, exp_sat);
        @(negedge clk);
        s_in_valid = 1'b1;
        s_in_res   = 8'(res);
        @(posedge clk);
        #1 s_in_valid = 1'b0;
        lat = 0;
        while (!s_out_valid && lat < 200) begin
            @(posedge clk);
            #1 lat++;
        end
        check("s_latency", lat, exp_lat);
        check("s_out_val", $signed(s_out_val), mv);
        check("s_out_sat", s_out_sat, sat);
        @(posedge clk);
        #1 check("s_retired", s_out_valid, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        int res, lat, v, q;
        bit sat;
        q = Q_MOD_L;

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", a_out_valid, 0);
        check("rst_out_val", a_out_val, 0);
        check("rst_out_sat", a_out_sat, 0);
        check("rst_busy", a_busy, 0);
        check("rst_in_ready", a_in_ready, 1);
        check("rst_dbg_state", a_dbg, 0);
        @(negedge clk) rst_n = 1'b1;

        send_a(0, 0, 2, 0);
        send_a(8, 8, 2, 0);
        send_a(9, -8, 2, 0);
        send_a(16, -1, 2, 0);
        send_a(20, 3, 3, 0);
        send_a(255, 0, 17, 0);
        send_a(12, -5, 2, 5);

        // Reset during REDUCE of 200 drops the item; out_val was -5 before.
        @(negedge clk);
        a_in_valid = 1'b1;
        a_in_res   = 8'd200;
        @(posedge clk);
        #1 a_in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", a_out_valid, 0);
        check("midrst_out_val", a_out_val, 0);
        check("midrst_out_sat", a_out_sat, 0);
        check("midrst_busy", a_busy, 0);
        check("midrst_in_ready", a_in_ready, 1);
        @(negedge clk) rst_n = 1'b1;
        send_a(5, 5, 2, 0);
        repeat (3) begin
            @(negedge clk);
            check("a_idle_after", a_busy, 0);
        end

        send_s(255, 0, 1, 6);
        send_s(3, 3, 0, 2);

        for (int i = 0; i < 10000; i++) begin
            res = int'($urandom_range(0, q - 1));
            @(negedge clk);
            d_in_valid = 1'b1;
            d_in_res   = W_BITS_L'(res);
            @(posedge clk);
            #1 d_in_valid = 1'b0;
            lat = 0;
            while (!d_out_valid && lat < 200) begin
                @(posedge clk);
                #1 lat++;
            end
            v = int'($signed(d_out_val));
            check("d_roundtrip", ((v % q) + q) % q, res);
            check("d_range", ((v <= q / 2) && (v >= -(q / 2))), 1);
            check("d_sat", d_out_sat, 0);
            @(posedge clk);
            #1;
        end

        v = lift_ref(1665, q, 64, sat);
        check("d_model_pin_neg", v, -1664);
        v = lift_ref(1664, q, 64, sat);
        check("d_model_pin_pos", v, 1664);

        check("a_queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
